// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
//   Two-stage pipelined MIPS R-type shift execution unit.
//   Stage A registers the decoded operation; a barrel shifter plus sign fill
//   sits between A and B; stage B is the result register for writeback.
//   One operation per cycle, full valid/ready backpressure, synchronous flush.
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   flush                  : kill everything in flight; inputs this cycle dropped
//   in_valid / in_ready    : upstream handshake
//   in_funct, in_shamt     : MIPS funct field and immediate shift amount
//   in_rs, in_rt           : variable amount source (low SW bits) / value to shift
//   in_dest                : destination register index (passed through)
//   out_valid / out_ready  : downstream handshake
//   out_result, out_dest   : shifted value and destination index
//   out_illegal            : funct was not one of the six shift opcodes
//   ops_done               : wrapping count of results handed downstream
// -----------------------------------------------------------------------------

// Logarithmic shifter: direction 0 = left, 1 = logical right.
module barrel_shifter32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shift_amount,
    input  logic                     direction,
    output logic [WIDTH-1:0]         data_out
);
    localparam int SW = $clog2(WIDTH);

    always_comb begin
        data_out = data_in;
        for (int i = 0; i < SW; i++) begin
            if (shift_amount[i]) begin
                data_out = direction ? (data_out >> (1 << i)) : (data_out << (1 << i));
            end
        end
    end
endmodule

module shift_exec_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_shamt,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic [4:0]       in_dest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_dest,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ops_done
);
    localparam int SW  = $clog2(WIDTH);
    // Immediate amount is 5 bits: truncate for narrow datapaths, zero-extend for 64.
    localparam int SHW = (SW < 5) ? SW : 5;

    // Stage A registers
    logic             r_a_valid;
    logic [WIDTH-1:0] r_a_rt;
    logic [SW-1:0]    r_a_amt;
    logic             r_a_dir;
    logic             r_a_arith;
    logic             r_a_illegal;
    logic [4:0]       r_a_dest;

    // Stage B registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [4:0]       r_out_dest;
    logic             r_out_illegal;
    logic [CNT_W-1:0] r_ops_done;

    logic [SW-1:0]    w_shamt;
    logic [SW-1:0]    w_amt;
    logic             w_dir;
    logic             w_arith;
    logic             w_illegal;
    logic             w_b_advance;
    logic             w_accept;
    logic             w_handoff;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_result;
    logic             w_unused_bits;

    // Upper rs bits (and shamt bits on narrow datapaths) carry no meaning here.
    assign w_unused_bits = ^{in_rs, in_shamt};

    assign w_shamt = SW'(in_shamt[SHW-1:0]);

    always_comb begin
        w_amt     = '0;
        w_dir     = 1'b0;
        w_arith   = 1'b0;
        w_illegal = 1'b0;
        case (in_funct)
            6'b000000: begin w_dir = 1'b0; w_amt = w_shamt; end
            6'b000010: begin w_dir = 1'b1; w_amt = w_shamt; end
            6'b000011: begin w_dir = 1'b1; w_amt = w_shamt; w_arith = 1'b1; end
            6'b000100: begin w_dir = 1'b0; w_amt = in_rs[SW-1:0]; end
            6'b000110: begin w_dir = 1'b1; w_amt = in_rs[SW-1:0]; end
            6'b000111: begin w_dir = 1'b1; w_amt = in_rs[SW-1:0]; w_arith = 1'b1; end
            default:   w_illegal = 1'b1;
        endcase
    end

    // A advances exactly when B can take its contents.
    assign w_b_advance = !r_out_valid || out_ready;
    assign in_ready    = !r_a_valid || w_b_advance;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_handoff   = r_out_valid && out_ready && !flush;

    // ---- Stage A -> B boundary: shift, sign fill, illegal squash ----
    barrel_shifter32 #(.WIDTH(WIDTH)) u_shifter (
        .data_in      (r_a_rt),
        .shift_amount (r_a_amt),
        .direction    (r_a_dir),
        .data_out     (w_shifted)
    );

    always_comb begin
        w_result = w_shifted;
        if (r_a_arith && r_a_rt[WIDTH-1]) begin
            w_result = w_shifted | ~({WIDTH{1'b1}} >> r_a_amt);
        end
        if (r_a_illegal) begin
            w_result = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid     <= 1'b0;
            r_a_rt        <= '0;
            r_a_amt       <= '0;
            r_a_dir       <= 1'b0;
            r_a_arith     <= 1'b0;
            r_a_illegal   <= 1'b0;
            r_a_dest      <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_dest    <= '0;
            r_out_illegal <= 1'b0;
            r_ops_done    <= '0;
        end else begin
            if (w_handoff) begin
                r_ops_done <= r_ops_done + CNT_W'(1);
            end
            if (flush) begin
                r_a_valid   <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                // ---- Input -> stage A ----
                if (in_ready) begin
                    r_a_valid <= in_valid;
                end
                if (w_accept) begin
                    r_a_rt      <= in_rt;
                    r_a_amt     <= w_amt;
                    r_a_dir     <= w_dir;
                    r_a_arith   <= w_arith;
                    r_a_illegal <= w_illegal;
                    r_a_dest    <= in_dest;
                end
                // ---- Stage A -> stage B ----
                if (w_b_advance) begin
                    r_out_valid <= r_a_valid;
                    if (r_a_valid) begin
                        r_out_result  <= w_result;
                        r_out_dest    <= r_a_dest;
                        r_out_illegal <= r_a_illegal;
                    end
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_dest    = r_out_dest;
    assign out_illegal = r_out_illegal;
    assign ops_done    = r_ops_done;
endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_funct;
    logic [4:0]       in_shamt;
    logic [WIDTH-1:0] in_rs;
    logic [WIDTH-1:0] in_rt;
    logic [4:0]       in_dest;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_dest;
    logic             out_illegal;
    logic [CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    shift_exec_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct    (in_funct),
        .in_shamt    (in_shamt),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_dest     (in_dest),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_dest    (out_dest),
        .out_illegal (out_illegal),
        .ops_done    (ops_done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   m_ops = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS shift semantics expressed with native operators.
    function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] d);
        exp_t e;
        e.dest = d;
        e.ill  = 1'b0;
        case (f)
            6'h00:   e.res = rt << sh;
            6'h02:   e.res = rt >> sh;
            6'h03:   e.res = $signed(rt) >>> sh;
            6'h04:   e.res = rt << rs[4:0];
            6'h06:   e.res = rt >> rs[4:0];
            6'h07:   e.res = $signed(rt) >>> rs[4:0];
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    // Scoreboard: sample handshakes on the falling edge.
    exp_t e_mon;
    always @(negedge clk) begin
        if (rst_n) begin
            check("ops_done", ops_done, m_ops[CNT_W-1:0]);
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("sb_underflow", q.size(), 1);
                    end else begin
                        e_mon = q.pop_front();
                        check("sb_result", out_result, e_mon.res);
                        check("sb_dest", out_dest, e_mon.dest);
                        check("sb_illegal", out_illegal, e_mon.ill);
                    end
                    m_ops++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(in_funct, in_shamt, in_rs, in_rt, in_dest));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [5:0] f, input logic [4:0] sh,
                          input logic [31:0] rs, input logic [31:0] rt);
        in_funct = f;
        in_shamt = sh;
        in_rs    = rs;
        in_rt    = rt;
        in_dest  = 5'($urandom);
    endtask

    // Single operation into an empty pipeline with out_ready=1.
    task automatic run_one(input logic [5:0] f, input logic [4:0] sh,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] exp_res, input logic exp_ill,
                           input string tag);
        int n;
        int lat;
        set_op(f, sh, rs, rt);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin tick(); lat++; end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_ill"}, out_illegal, exp_ill);
        tick();
    endtask

    logic [5:0] flist [7] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20};

    initial begin
        int base;
        int n;
        int k;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op(6'h00, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_dest", out_dest, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_ops_done", ops_done, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        tick();

        // Directed operations
        run_one(6'h00, 5'd31, 32'h0, 32'h00000001, 32'h80000000, 1'b0, "sll31");
        check("ops_done_first", ops_done, 1);
        run_one(6'h03, 5'd4, 32'h0, 32'h80000000, 32'hF8000000, 1'b0, "sra4");
        run_one(6'h02, 5'd4, 32'h0, 32'h80000000, 32'h08000000, 1'b0, "srl4");
        run_one(6'h03, 5'd0, 32'h0, 32'h80000000, 32'h80000000, 1'b0, "sra0");
        run_one(6'h06, 5'd0, 32'h25, 32'hFFFF0000, 32'h07FFF800, 1'b0, "srlv5");
        run_one(6'h04, 5'd7, 32'h0, 32'h12345678, 32'h12345678, 1'b0, "sllv0");
        run_one(6'h07, 5'd0, 32'h3F, 32'h80000001, 32'hFFFFFFFF, 1'b0, "srav31");
        run_one(6'h20, 5'd3, 32'h1, 32'hFFFFFFFF, 32'h00000000, 1'b1, "illegal");

        // Backpressure: two accepted, third blocked, output held
        out_ready = 1'b0;
        base = int'(ops_done);
        set_op(6'h00, 5'd1, 32'h0, 32'h3);
        in_valid = 1'b1;
        check("bp_rdy1", in_ready, 1);
        tick();
        set_op(6'h02, 5'd4, 32'h0, 32'h100);
        check("bp_rdy2", in_ready, 1);
        tick();
        set_op(6'h03, 5'd31, 32'h0, 32'h80000000);
        for (int i = 0; i < 4; i++) begin
            check("bp_rdy3", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_res", out_result, 32'h6);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_seq2", out_result, 32'h10);
        tick();
        check("bp_seq3", out_result, 32'hFFFFFFFF);
        check("bp_seq3_valid", out_valid, 1);
        tick();
        check("bp_drained", out_valid, 0);
        check("bp_ops", ops_done, base + 3);

        // Flush with two in flight and out_ready high
        set_op(6'h00, 5'd1, 32'h0, 32'h1);
        in_valid = 1'b1;
        tick();
        set_op(6'h00, 5'd2, 32'h0, 32'h1);
        tick();
        base = int'(ops_done);
        check("fl_inflight", out_valid, 1);
        flush = 1'b1;
        set_op(6'h00, 5'd3, 32'h0, 32'h1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        tick();
        check("fl_a_empty", out_valid, 0);
        check("fl_ops", ops_done, base);
        tick();

        // Async reset between edges with two in flight
        out_ready = 1'b0;
        set_op(6'h00, 5'd3, 32'h0, 32'h5);
        in_valid = 1'b1;
        tick();
        set_op(6'h02, 5'd1, 32'h0, 32'h8);
        tick();
        in_valid = 1'b0;
        check("ar_pre_res", out_result, 32'h28);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_result", out_result, 0);
        check("ar_ops", ops_done, 0);
        q.delete();
        m_ops = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        run_one(6'h03, 5'd8, 32'h0, 32'h80F00000, 32'hFF80F000, 1'b0, "ar_sra");
        run_one(6'h06, 5'd0, 32'h24, 32'hF0000000, 32'h0F000000, 1'b0, "ar_srlv");

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 6);
            set_op((k == 6) ? 6'($urandom) : flist[k], 5'($urandom), $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 20) begin tick(); n++; end
        check("drain_queue", q.size(), 0);
        check("drain_valid", out_valid, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
